// File: rtl/first_counter.sv
// -----------------------------------------------------------------------------
// first_counter
//   Synchronous up-counter with count enable, synchronous active-high reset and
//   a programmable modulus (counts 0..MAX_VALUE, then wraps to 0).
//
// Ports
//   clock        in   rising-edge clock, the only clock domain
//   reset        in   synchronous, active-high; dominates enable
//   enable       in   count enable, sampled at posedge clock
//   counter_out  out  [WIDTH-1:0] current count, registered
//   terminal     out  combinational: counter_out == MAX_VALUE while enable is high
//   wrap         out  registered one-cycle strobe after a MAX_VALUE -> 0 edge
//   wrap_count   out  [7:0] saturating wrap event count, registered
//                     (only when FIRST_COUNTER_WRAP_COUNT_EN is defined)
//
// Build option
//   FIRST_COUNTER_WRAP_COUNT_EN : adds the wrap_count output and its logic.
// -----------------------------------------------------------------------------
module first_counter #(
  parameter int unsigned            WIDTH       = 4,
  parameter logic [WIDTH-1:0]       MAX_VALUE   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] counter_out,
  output logic             terminal,
`ifdef FIRST_COUNTER_WRAP_COUNT_EN
  output logic             wrap,
  output logic [7:0]       wrap_count
`else
  output logic             wrap
`endif
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  // Explicit compare against MAX_VALUE so a non-power-of-two modulus wraps
  // correctly instead of relying on binary overflow.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (enable) begin
      if (count_q < MAX_VALUE) begin
        count_d = count_q + WIDTH'(1);
      end else begin
        count_d = '0;
        wrap_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= RESET_VALUE;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign counter_out = count_q;
  assign wrap        = wrap_q;
  assign terminal    = enable && (count_q == MAX_VALUE);

`ifdef FIRST_COUNTER_WRAP_COUNT_EN
  logic [7:0] wcnt_q, wcnt_d;

  // Counts the same edges that raise wrap; holds at 255 once saturated.
  always_comb begin
    wcnt_d = wcnt_q;
    if (wrap_d && (wcnt_q != 8'hFF)) begin
      wcnt_d = wcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt_q <= 8'd0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  assign wrap_count = wcnt_q;
`endif

endmodule

// File: tb/tb_first_counter.sv
// -----------------------------------------------------------------------------
// tb_first_counter
//   Two instances share clock/reset/enable: one with default parameters
//   (modulus 16) and one with MAX_VALUE = 9 (modulus 10). A behavioural model
//   computes each expected count as (count + 1) mod (MAX_VALUE + 1).
// -----------------------------------------------------------------------------
module tb_first_counter;

  localparam int MAX0 = 15;
  localparam int MAX1 = 9;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [3:0] counter_out0, counter_out1;
  logic       terminal0, terminal1;
  logic       wrap0, wrap1;
`ifdef FIRST_COUNTER_WRAP_COUNT_EN
  logic [7:0] wrap_count0, wrap_count1;
`endif

  int tests = 0;
  int fails = 0;

  // Model state
  bit valid = 0;
  int m0, m1;
  int w0, w1;
  int wc0, wc1;

  first_counter #(.WIDTH(4)) dut0 (
    .clock(clock), .reset(reset), .enable(enable),
    .counter_out(counter_out0), .terminal(terminal0),
`ifdef FIRST_COUNTER_WRAP_COUNT_EN
    .wrap(wrap0), .wrap_count(wrap_count0)
`else
    .wrap(wrap0)
`endif
  );

  first_counter #(.WIDTH(4), .MAX_VALUE(4'd9), .RESET_VALUE(4'd0)) dut1 (
    .clock(clock), .reset(reset), .enable(enable),
    .counter_out(counter_out1), .terminal(terminal1),
`ifdef FIRST_COUNTER_WRAP_COUNT_EN
    .wrap(wrap1), .wrap_count(wrap_count1)
`else
    .wrap(wrap1)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check terminal before the edge,
  // advance the model at posedge, check registered outputs just after it.
  task automatic step(input logic r, input logic e);
    @(negedge clock);
    reset  = r;
    enable = e;
    #1;
    if (valid) begin
      check("terminal0", {31'd0, terminal0}, (e && m0 == MAX0) ? 1 : 0);
      check("terminal1", {31'd0, terminal1}, (e && m1 == MAX1) ? 1 : 0);
    end
    @(posedge clock);
    if (r) begin
      valid = 1;
      m0 = 0; m1 = 0; w0 = 0; w1 = 0; wc0 = 0; wc1 = 0;
    end else if (valid) begin
      w0 = (e && m0 == MAX0) ? 1 : 0;
      w1 = (e && m1 == MAX1) ? 1 : 0;
      if (e) begin
        m0 = (m0 + 1) % (MAX0 + 1);
        m1 = (m1 + 1) % (MAX1 + 1);
      end
      if (w0 == 1 && wc0 < 255) wc0++;
      if (w1 == 1 && wc1 < 255) wc1++;
    end
    #1;
    if (valid) begin
      check("count0", {28'd0, counter_out0}, m0);
      check("count1", {28'd0, counter_out1}, m1);
      check("wrap0",  {31'd0, wrap0}, w0);
      check("wrap1",  {31'd0, wrap1}, w1);
`ifdef FIRST_COUNTER_WRAP_COUNT_EN
      check("wrap_count0", {24'd0, wrap_count0}, wc0);
      check("wrap_count1", {24'd0, wrap_count1}, wc1);
`endif
    end
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;

    // Reset then count 10
    step(1, 0);
    check("reset_count0", {28'd0, counter_out0}, 0);
    check("reset_wrap0",  {31'd0, wrap0}, 0);
    repeat (10) step(0, 1);
    check("count_after10", {28'd0, counter_out0}, 10);

    // Full wrap at modulus 16 (and modulus 10 in parallel)
    step(1, 0);
    repeat (15) step(0, 1);
    check("at15", {28'd0, counter_out0}, 15);
    check("term_at15", {31'd0, terminal0}, 1);
    step(0, 1);
    check("wrapped_to0", {28'd0, counter_out0}, 0);
    check("wrap_strobe", {31'd0, wrap0}, 1);
    step(0, 1);
    check("wrap_cleared", {31'd0, wrap0}, 0);
    check("after_wrap1", {28'd0, counter_out0}, 1);

    // Modulus 10 sequence: 12 edges from 0 -> ends at 2
    step(1, 0);
    repeat (12) step(0, 1);
    check("mod10_end", {28'd0, counter_out1}, 2);

    // Hold
    step(1, 0);
    repeat (5) step(0, 1);
    repeat (3) step(0, 0);
    check("hold5", {28'd0, counter_out0}, 5);
    step(0, 1);
    check("resume6", {28'd0, counter_out0}, 6);

    // Reset priority mid-count
    step(1, 0);
    repeat (9) step(0, 1);
    step(1, 1);
    check("rst_prio", {28'd0, counter_out0}, 0);
    check("rst_prio_wrap", {31'd0, wrap0}, 0);
    step(0, 1);
    check("after_rst1", {28'd0, counter_out0}, 1);

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0));
    end

`ifdef FIRST_COUNTER_WRAP_COUNT_EN
    step(1, 0);
    repeat (48) step(0, 1);
    check("wc_48", {24'd0, wrap_count0}, 3);
    repeat (260 * 16) step(0, 1);
    check("wc_sat", {24'd0, wrap_count0}, 255);
    step(1, 0);
    check("wc_reset", {24'd0, wrap_count0}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/first_counter.md
Name: first_counter

Overview:
- Synchronous up-counter with count enable, synchronous reset and programmable modulus.
- Drives a binary count plus terminal-count and wrap indications.
- Used as a basic timing/sequence source; downstream blocks sample `counter_out` and the wrap strobe on the same clock.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..32.
- MAX_VALUE, 2**WIDTH-1, last count before wrap; legal range 0..2**WIDTH-1.
- RESET_VALUE, 0, value loaded by reset; must be <= MAX_VALUE.

Ports:
- clock  input  1  rising-edge clock; all state changes on its posedge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable, sampled at posedge clock.
- counter_out  output  WIDTH  current count, registered.
- terminal  output  1  combinational; high when counter_out == MAX_VALUE and enable == 1.
- wrap  output  1  registered one-cycle strobe; high in the cycle after counter_out wraps MAX_VALUE -> 0.

Behaviour:
- One clock domain (clock); reset is synchronous and active-high; no asynchronous reset path.
- Reset: at a posedge with reset == 1, counter_out <= RESET_VALUE and wrap <= 0.
  - Reset dominates enable.
  - Reset asserted mid-count takes effect at that same edge.
- Count: at a posedge with reset == 0 and enable == 1:
  - counter_out <= counter_out + 1 when counter_out < MAX_VALUE;
  - otherwise counter_out <= 0 and wrap <= 1.
- Hold: at a posedge with reset == 0 and enable == 0, counter_out holds and wrap <= 0.
- wrap is 0 at every posedge except the wrapping edge, so it is never high for two consecutive cycles unless MAX_VALUE == 0.
  - With MAX_VALUE == 0 and enable held high, counter_out stays 0 and wrap stays 1.
- Latency: counter_out reflects an enabled edge immediately after that edge, with no pipeline.
- terminal is combinational from counter_out and enable; it has no register and asserts in the cycle before the wrap edge.
- Arithmetic is unsigned, modulo MAX_VALUE+1.
  - With MAX_VALUE == 2**WIDTH-1 the natural binary overflow gives the wrap.
  - The compare must still be explicit so that a non-power-of-two modulus works.
- Before the first reset, outputs are undefined (X in simulation). The system must apply reset for at least one posedge before use.
- enable changing between edges has no effect; only the value at the posedge matters.

Optional Feature:
- Macro FIRST_COUNTER_WRAP_COUNT_EN.
- When defined:
  - Adds output port wrap_count, 8 bits, registered.
  - Reset clears it to 0.
  - It increments by 1 at each wrap edge and saturates at 255.
  - It is unaffected by enable except through wrap events.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then count: clock low, reset=1 at one posedge, then reset=0, enable=1 for 10 posedges -> counter_out = 0 after reset, then 1..10 (0xA); terminal=0 and wrap=0 throughout.
- Wrap: defaults, enable=1 for 16 posedges from 0 -> counter_out 15 after edge 15 with terminal=1; counter_out 0 and wrap=1 after edge 16; wrap=0 after edge 17 with counter_out=1.
- Hold: count to 5, enable=0 for 3 posedges -> counter_out stays 5, terminal=0, wrap=0; enable=1 again -> 6 on the next edge.
- Reset priority mid-count: counter_out=9, reset=1 and enable=1 at the same posedge -> counter_out=0 and wrap=0; the next enabled edge gives 1.
- Non-power-of-two modulus: WIDTH=4, MAX_VALUE=9, enable=1 for 12 posedges -> sequence 1..9, 0, 1, 2; wrap=1 only after edge 10; terminal=1 only while counter_out=9.
- FIRST_COUNTER_WRAP_COUNT_EN defined: defaults, enable=1 for 48 posedges -> wrap_count=3. Forcing 260 wraps -> wrap_count saturates at 255. Reset -> wrap_count=0.
